// File: rtl/adc_proc_pkg.sv
// adc_proc_pkg: shared types and constants for the ADC sample post-processor.
//   adc_state_e  : processing state (IDLE, CAL, RUN)
//   ADC_W        : sample width
//   SAT_MAX/MIN  : signed 16-bit saturation limits (17-bit compare form)
//   OC_LIMIT_DEF, OFFSET_DEF : default parameter values for adc_sample_proc
//   sat16()      : clamp a 17-bit signed difference into 16 bits
package adc_proc_pkg;

  localparam int ADC_W = 16;

  localparam logic signed [16:0] SAT_MAX = 17'sd32767;
  localparam logic signed [16:0] SAT_MIN = -17'sd32768;

  localparam logic [15:0] OC_LIMIT_DEF = 16'd28000;
  localparam logic [15:0] OFFSET_DEF   = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } adc_state_e;

  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v > SAT_MAX)      return 16'h7FFF;
    else if (v < SAT_MIN) return 16'h8000;
    else                  return v[15:0];
  endfunction

endpackage

// File: rtl/adc_iir_lp.sv
// adc_iir_lp: one channel of the first-order IIR low-pass filter.
//   acc <= acc + din - (acc >>> ALPHA_SHIFT); dout = acc >>> ALPHA_SHIFT.
//   With seed high, the update loads acc <= din <<< ALPHA_SHIFT so dout == din.
// Ports:
//   clk, rst_n : clock, async active-low reset (acc clears to 0)
//   en         : apply one filter update this cycle
//   seed       : when en, load instead of accumulate
//   din        : signed 16-bit corrected sample
//   dout       : signed 16-bit filtered value (tracks the register, holds when en low)
module adc_iir_lp
  import adc_proc_pkg::*;
#(
  parameter int ALPHA_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        seed,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  localparam int ACC_W = ADC_W + ALPHA_SHIFT + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [ACC_W-1:0] acc_seed;
  // Two guard bits so the intermediate sum never wraps; the result fits ACC_W.
  logic signed [ACC_W+1:0] acc_sum;

  always_comb begin
    acc_shr  = acc >>> ALPHA_SHIFT;
    acc_seed = ACC_W'($signed(din)) <<< ALPHA_SHIFT;
    acc_sum  = (ACC_W+2)'(acc) + (ACC_W+2)'($signed(din)) - (ACC_W+2)'(acc_shr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= seed ? acc_seed : acc_sum[ACC_W-1:0];
    end
  end

  assign dout = acc_shr[15:0];

endmodule

// File: rtl/adc_sample_proc.sv
// adc_sample_proc: offset correction, calibration, IIR filtering and latched
// overcurrent detection for a dual-channel 16-bit offset-binary ADC stream.
// Optional feature macro: ADC_PROC_OC_EN (overcurrent fault logic).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   conv_done            : one-cycle sample strobe, data_a_in/data_b_in valid with it
//   cal_start            : starts/restarts offset calibration
//   fault_clr            : clears the latched overcurrent fault
//   out_valid            : one-cycle pulse, 2 cycles after a processed conv_done
//   corr_a/b, filt_a/b   : signed corrected / filtered samples
//   cal_busy, cal_done   : calibration in progress / completion pulse
//   oc_fault, oc_chan    : latched overcurrent fault and tripping channels (bit0 A, bit1 B)
//   state_dbg            : current FSM state (adc_state_e encoding)
// Handshake: conv_done is a strobe with no back-pressure; out_valid is a strobe
// and all data outputs hold their value until the next out_valid.
module adc_sample_proc
  import adc_proc_pkg::*;
#(
  parameter int          CAL_SHIFT      = 6,
  parameter int          ALPHA_SHIFT    = 3,
  parameter logic [15:0] OFFSET_DEFAULT = OFFSET_DEF,
  parameter logic [15:0] OC_LIMIT       = OC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        conv_done,
  input  logic [15:0] data_a_in,
  input  logic [15:0] data_b_in,
  input  logic        cal_start,
  input  logic        fault_clr,
  output logic        out_valid,
  output logic [15:0] corr_a,
  output logic [15:0] corr_b,
  output logic [15:0] filt_a,
  output logic [15:0] filt_b,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        oc_fault,
  output logic [1:0]  oc_chan,
  output logic [1:0]  state_dbg
);

  localparam int CAL_W = ADC_W + CAL_SHIFT;
  localparam int CNT_W = CAL_SHIFT + 1;
  localparam int CAL_N = 1 << CAL_SHIFT;

  adc_state_e state, state_nxt;

  logic [CNT_W-1:0] cal_cnt;
  logic [CAL_W-1:0] cal_acc_a, cal_acc_b, cal_sum_a, cal_sum_b;
  logic [15:0]      off_a, off_b;
  logic             cal_last, take, cal_take;

  logic signed [16:0] diff_a, diff_b;
  logic [15:0]        corr_a_c, corr_b_c;

  logic        s1_valid;
  logic [15:0] s1_corr_a, s1_corr_b;
  logic        seed_pend;

  // cal_start always wins over a coincident conv_done: that sample is dropped.
  assign take     = conv_done && !cal_start && (state != ST_CAL);
  assign cal_take = conv_done && !cal_start && (state == ST_CAL);
  assign cal_last = (cal_cnt == CNT_W'(CAL_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN: if (cal_start) state_nxt = ST_CAL;
      ST_CAL: begin
        if (cal_take && cal_last) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cal_busy  = (state == ST_CAL);
  assign state_dbg = state;

  // Calibration accumulators; the final sample is folded in combinationally
  // so the average is taken on the same edge that samples it.
  always_comb begin
    cal_sum_a = cal_acc_a + CAL_W'(data_a_in);
    cal_sum_b = cal_acc_b + CAL_W'(data_b_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt   <= '0;
      cal_acc_a <= '0;
      cal_acc_b <= '0;
      off_a     <= OFFSET_DEFAULT;
      off_b     <= OFFSET_DEFAULT;
      cal_done  <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      if (cal_start) begin
        cal_cnt   <= '0;
        cal_acc_a <= '0;
        cal_acc_b <= '0;
      end else if (cal_take) begin
        if (cal_last) begin
          off_a    <= 16'(cal_sum_a >> CAL_SHIFT);
          off_b    <= 16'(cal_sum_b >> CAL_SHIFT);
          cal_done <= 1'b1;
        end else begin
          cal_cnt   <= cal_cnt + CNT_W'(1);
          cal_acc_a <= cal_sum_a;
          cal_acc_b <= cal_sum_b;
        end
      end
    end
  end

  // Offset correction in 17 bits so the full unsigned range is representable.
  always_comb begin
    diff_a   = $signed({1'b0, data_a_in}) - $signed({1'b0, off_a});
    diff_b   = $signed({1'b0, data_b_in}) - $signed({1'b0, off_b});
    corr_a_c = sat16(diff_a);
    corr_b_c = sat16(diff_b);
  end

  // Stage 1: register corrected samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_corr_a <= '0;
      s1_corr_b <= '0;
    end else begin
      s1_valid <= take;
      if (take) begin
        s1_corr_a <= corr_a_c;
        s1_corr_b <= corr_b_c;
      end
    end
  end

  // Stage 2: publish corrected values; the filter updates in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      corr_a    <= '0;
      corr_b    <= '0;
      seed_pend <= 1'b1;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        corr_a <= s1_corr_a;
        corr_b <= s1_corr_b;
      end
      if (cal_take && cal_last) seed_pend <= 1'b1;
      else if (s1_valid)        seed_pend <= 1'b0;
    end
  end

  adc_iir_lp #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_a (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (s1_valid),
    .seed (seed_pend),
    .din  (s1_corr_a),
    .dout (filt_a)
  );

  adc_iir_lp #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_b (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (s1_valid),
    .seed (seed_pend),
    .din  (s1_corr_b),
    .dout (filt_b)
  );

`ifdef ADC_PROC_OC_EN
  logic [16:0] abs_a, abs_b;
  logic [1:0]  trip_c, s1_trip;

  // 17-bit magnitude so that -32768 maps to 32768 instead of wrapping.
  always_comb begin
    abs_a  = corr_a_c[15] ? (17'd0 - {corr_a_c[15], corr_a_c}) : {1'b0, corr_a_c};
    abs_b  = corr_b_c[15] ? (17'd0 - {corr_b_c[15], corr_b_c}) : {1'b0, corr_b_c};
    trip_c = {abs_b > {1'b0, OC_LIMIT}, abs_a > {1'b0, OC_LIMIT}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_trip  <= '0;
      oc_fault <= 1'b0;
      oc_chan  <= '0;
    end else begin
      if (take) s1_trip <= trip_c;
      // A trip coincident with fault_clr: clear first, then set (set wins).
      if (s1_valid && (s1_trip != 2'b00)) begin
        oc_fault <= 1'b1;
        oc_chan  <= (fault_clr ? 2'b00 : oc_chan) | s1_trip;
      end else if (fault_clr) begin
        oc_fault <= 1'b0;
        oc_chan  <= '0;
      end
    end
  end
`else
  logic                 unused_fault_clr;
  localparam logic [15:0] UNUSED_OC_LIMIT = OC_LIMIT;
  assign unused_fault_clr = fault_clr;
  assign oc_fault = 1'b0;
  assign oc_chan  = 2'b00;
`endif

endmodule
